// File: rtl/mem_stage_if.sv
// Signal bundle between the memory-stage controller, the EX/MEM and MEM/WB
// registers and the data memory. The slave view belongs to the controller.
interface mem_stage_if;
    logic        valid_in;
    logic        mem_read_in;
    logic        mem_write_in;
    logic [15:0] addr_in;
    logic [15:0] wr_data_in;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_stall;
    logic        mem_done;
    logic [15:0] mem_rdata;
    logic        stall_out;
    logic [15:0] read_data_out;
    logic        err_out;

    // Request: mem_rd/mem_wr are held with mem_addr/mem_wdata until a cycle with
    // mem_stall=0; the access then completes on the first cycle mem_done=1.
    modport slave (
        input  valid_in, mem_read_in, mem_write_in, addr_in, wr_data_in,
        input  mem_stall, mem_done, mem_rdata,
        output mem_rd, mem_wr, mem_addr, mem_wdata,
        output stall_out, read_data_out, err_out
    );

    modport master (
        output valid_in, mem_read_in, mem_write_in, addr_in, wr_data_in,
        output mem_stall, mem_done, mem_rdata,
        input  mem_rd, mem_wr, mem_addr, mem_wdata,
        input  stall_out, read_data_out, err_out
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: issues loads/stores to a stallable data memory,
// freezes the pipeline until completion and flags bad or timed-out accesses.
module mem_stage_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    mem_stage_if.slave  bus,
    output logic [1:0]  state_dbg_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_ERR  = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [15:0]      req_addr_q, req_addr_d;
    logic [15:0]      req_wdata_q, req_wdata_d;
    logic             req_rd_q, req_rd_d;
    logic             req_wr_q, req_wr_d;
    logic [15:0]      rdata_q, rdata_d;

    logic        op, bad, accept;
    logic        rd_cmpl;
    logic        rd_c, wr_c, stall_c;
    logic [15:0] addr_c, wdata_c, read_data_c;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_rd_q    <= 1'b0;
            req_wr_q    <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_rd_q    <= req_rd_d;
            req_wr_q    <= req_wr_d;
            rdata_q     <= rdata_d;
        end
    end

    always_comb begin
        op      = bus.valid_in & (bus.mem_read_in | bus.mem_write_in);
        bad     = op & (bus.addr_in[0] | (bus.mem_read_in & bus.mem_write_in));
        accept  = op & ~bad;
        cnt_inc = cnt_q + CNT_W'(1);

        state_d     = state_q;
        cnt_d       = '0;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_rd_d    = req_rd_q;
        req_wr_d    = req_wr_q;
        rd_cmpl     = 1'b0;
        rd_c        = 1'b0;
        wr_c        = 1'b0;
        stall_c     = 1'b0;
        addr_c      = req_addr_q;
        wdata_c     = req_wdata_q;

        unique case (state_q)
            S_IDLE: begin
                addr_c  = bus.addr_in;
                wdata_c = bus.wr_data_in;
                if (bad) begin
                    state_d = S_ERR;
                    stall_c = 1'b1;
                end else if (accept) begin
                    rd_c        = bus.mem_read_in;
                    wr_c        = bus.mem_write_in;
                    req_addr_d  = bus.addr_in;
                    req_wdata_d = bus.wr_data_in;
                    req_rd_d    = bus.mem_read_in;
                    req_wr_d    = bus.mem_write_in;
                    if (bus.mem_stall) begin
                        state_d = S_REQ;
                        stall_c = 1'b1;
                    end else if (bus.mem_done) begin
                        rd_cmpl = bus.mem_read_in;
                    end else begin
                        state_d = S_WAIT;
                        stall_c = 1'b1;
                    end
                end
            end
            S_REQ: begin
                rd_c  = req_rd_q;
                wr_c  = req_wr_q;
                cnt_d = cnt_inc;
                if (!bus.mem_stall && bus.mem_done) begin
                    state_d = S_IDLE;
                    rd_cmpl = req_rd_q;
                end else begin
                    stall_c = 1'b1;
                    // A completion in the cycle the limit is hit takes priority.
                    if (cnt_inc == TO_CNT) state_d = S_ERR;
                    else if (!bus.mem_stall) state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d   = cnt_inc;
                stall_c = ~(bus.mem_done & ~bus.mem_stall);
                if (bus.mem_done) begin
                    state_d = S_IDLE;
                    rd_cmpl = req_rd_q;
                end else if (cnt_inc == TO_CNT) begin
                    state_d = S_ERR;
                end
            end
            S_ERR: begin
                stall_c = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        rdata_d     = rd_cmpl ? bus.mem_rdata : rdata_q;
        read_data_c = rd_cmpl ? bus.mem_rdata : rdata_q;
    end

    // Outputs are held at zero for as long as reset is asserted.
    assign bus.mem_rd        = rst & rd_c;
    assign bus.mem_wr        = rst & wr_c;
    assign bus.mem_addr      = rst ? addr_c : 16'h0000;
    assign bus.mem_wdata     = rst ? wdata_c : 16'h0000;
    assign bus.stall_out     = rst & stall_c;
    assign bus.read_data_out = rst ? read_data_c : 16'h0000;
    assign bus.err_out       = rst & (state_q == S_ERR);
    assign state_dbg_o       = rst ? state_q : S_IDLE;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: one instance with the default timeout
// and one with TIMEOUT=4 for the timeout scenarios.
module tb_mem_stage_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] st;
    logic [1:0] st4;
    int         checks   = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    mem_stage_if bus ();
    mem_stage_if bus4 ();

    mem_stage_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .state_dbg_o (st)
    );

    mem_stage_ctrl #(.TIMEOUT(4), .CNT_W(8)) dut4 (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus4),
        .state_dbg_o (st4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.valid_in = 0; bus.mem_read_in = 0; bus.mem_write_in = 0;
        bus.addr_in = 16'h0; bus.wr_data_in = 16'h0;
        bus.mem_stall = 0; bus.mem_done = 0; bus.mem_rdata = 16'h0;
    endtask

    task automatic idle4();
        bus4.valid_in = 0; bus4.mem_read_in = 0; bus4.mem_write_in = 0;
        bus4.addr_in = 16'h0; bus4.wr_data_in = 16'h0;
        bus4.mem_stall = 0; bus4.mem_done = 0; bus4.mem_rdata = 16'h0;
    endtask

    task automatic do_reset();
        rst = 0;
        tick();
        rst = 1;
    endtask

    initial begin
        // Reset with live inputs: every output must read zero.
        rst = 0;
        idle(); idle4();
        bus.valid_in = 1; bus.mem_read_in = 1; bus.addr_in = 16'h0010;
        bus.mem_done = 1; bus.mem_rdata = 16'hFFFF;
        tick(); tick();
        chk("rst_mem_rd", bus.mem_rd, 0);
        chk("rst_stall", bus.stall_out, 0);
        chk("rst_rdata", bus.read_data_out, 16'h0000);
        chk("rst_err", bus.err_out, 0);
        chk("rst_addr", bus.mem_addr, 16'h0000);
        rst = 1; idle();
        tick();
        chk("idle_state", st, 0);

        // Single-cycle load.
        bus.valid_in = 1; bus.mem_read_in = 1; bus.addr_in = 16'h0010;
        bus.mem_done = 1; bus.mem_rdata = 16'hBEEF;
        #1;
        chk("ld1_mem_rd", bus.mem_rd, 1);
        chk("ld1_addr", bus.mem_addr, 16'h0010);
        chk("ld1_stall", bus.stall_out, 0);
        chk("ld1_rdata", bus.read_data_out, 16'hBEEF);
        tick(); idle(); #1;
        chk("ld1_state", st, 0);
        chk("ld1_rdata_held", bus.read_data_out, 16'hBEEF);

        // Busy then slow store: stall for 3 cycles, done on the 7th cycle.
        bus.valid_in = 1; bus.mem_write_in = 1;
        bus.addr_in = 16'h0100; bus.wr_data_in = 16'h1234;
        for (int i = 0; i < 7; i++) begin
            bus.mem_stall = (i < 3);
            bus.mem_done  = (i == 6);
            #1;
            chk($sformatf("st_wr_c%0d", i), bus.mem_wr, 16'(i < 4));
            chk($sformatf("st_stall_c%0d", i), bus.stall_out, 16'(i < 6));
            chk($sformatf("st_rdata_c%0d", i), bus.read_data_out, 16'hBEEF);
            if (i < 4) begin
                chk($sformatf("st_addr_c%0d", i), bus.mem_addr, 16'h0100);
                chk($sformatf("st_wdata_c%0d", i), bus.mem_wdata, 16'h1234);
            end
            tick();
        end
        idle(); #1;
        chk("st_state_after", st, 0);
        chk("st_rdata_after", bus.read_data_out, 16'hBEEF);

        // Back-to-back loads, each two cycles long.
        bus.valid_in = 1; bus.mem_read_in = 1; bus.addr_in = 16'h0000;
        #1;
        chk("bb1_mem_rd", bus.mem_rd, 1);
        chk("bb1_addr", bus.mem_addr, 16'h0000);
        chk("bb1_stall", bus.stall_out, 1);
        tick();
        bus.mem_done = 1; bus.mem_rdata = 16'h1111;
        #1;
        chk("bb1_done_stall", bus.stall_out, 0);
        chk("bb1_done_rdata", bus.read_data_out, 16'h1111);
        chk("bb1_done_mem_rd", bus.mem_rd, 0);
        tick();
        bus.addr_in = 16'h0002; bus.mem_done = 0; bus.mem_rdata = 16'h0000;
        #1;
        chk("bb2_mem_rd", bus.mem_rd, 1);
        chk("bb2_addr", bus.mem_addr, 16'h0002);
        chk("bb2_stall", bus.stall_out, 1);
        chk("bb2_rdata_prev", bus.read_data_out, 16'h1111);
        tick();
        bus.mem_done = 1; bus.mem_rdata = 16'h2222;
        #1;
        chk("bb2_done_stall", bus.stall_out, 0);
        chk("bb2_done_rdata", bus.read_data_out, 16'h2222);
        tick();

        // Spurious done in IDLE is ignored.
        idle(); bus.mem_done = 1; bus.mem_rdata = 16'hDEAD;
        #1;
        chk("spur_rdata", bus.read_data_out, 16'h2222);
        chk("spur_stall", bus.stall_out, 0);
        chk("spur_mem_rd", bus.mem_rd, 0);
        tick(); idle(); #1;
        chk("spur_rdata_held", bus.read_data_out, 16'h2222);

        // Reset in the middle of WAIT.
        bus.valid_in = 1; bus.mem_read_in = 1; bus.addr_in = 16'h0004;
        #1;
        chk("rw_accept_stall", bus.stall_out, 1);
        tick();
        chk("rw_wait_state", st, 2);
        chk("rw_wait_stall", bus.stall_out, 1);
        rst = 0; #1;
        chk("rw_rst_stall", bus.stall_out, 0);
        chk("rw_rst_rdata", bus.read_data_out, 16'h0000);
        chk("rw_rst_addr", bus.mem_addr, 16'h0000);
        tick();
        rst = 1; idle(); bus.mem_done = 1; bus.mem_rdata = 16'hABCD;
        #1;
        chk("rw_post_state", st, 0);
        chk("rw_post_rdata", bus.read_data_out, 16'h0000);
        tick(); idle(); #1;
        chk("rw_post_rdata_held", bus.read_data_out, 16'h0000);

        // Misaligned load goes to a sticky error.
        bus.valid_in = 1; bus.mem_read_in = 1; bus.addr_in = 16'h0011;
        #1;
        chk("mis_mem_rd", bus.mem_rd, 0);
        chk("mis_stall", bus.stall_out, 1);
        chk("mis_err_now", bus.err_out, 0);
        tick();
        chk("mis_err", bus.err_out, 1);
        chk("mis_state", st, 3);
        chk("mis_err_stall", bus.stall_out, 1);
        chk("mis_err_mem_rd", bus.mem_rd, 0);
        idle(); tick(); tick();
        chk("mis_err_sticky", bus.err_out, 1);
        do_reset(); #1;
        chk("mis_err_cleared", bus.err_out, 0);

        // Load and store asserted together is a conflict.
        bus.valid_in = 1; bus.mem_read_in = 1; bus.mem_write_in = 1; bus.addr_in = 16'h0020;
        #1;
        chk("cf_mem_rd", bus.mem_rd, 0);
        chk("cf_mem_wr", bus.mem_wr, 0);
        chk("cf_stall", bus.stall_out, 1);
        tick(); idle(); #1;
        chk("cf_err", bus.err_out, 1);
        do_reset(); #1;

        // Timeout with TIMEOUT=4: no done for four WAIT cycles.
        bus4.valid_in = 1; bus4.mem_read_in = 1; bus4.addr_in = 16'h0040;
        #1;
        chk("to_mem_rd", bus4.mem_rd, 1);
        chk("to_stall", bus4.stall_out, 1);
        tick();
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk($sformatf("to_wait%0d_state", i), st4, 2);
            chk($sformatf("to_wait%0d_err", i), bus4.err_out, 0);
            chk($sformatf("to_wait%0d_stall", i), bus4.stall_out, 1);
            tick();
        end
        chk("to_err", bus4.err_out, 1);
        chk("to_err_state", st4, 3);
        chk("to_err_mem_rd", bus4.mem_rd, 0);

        // Same load, done arrives on the 4th WAIT cycle: no error.
        do_reset(); #1;
        chk("to2_mem_rd", bus4.mem_rd, 1);
        chk("to2_stall", bus4.stall_out, 1);
        tick();
        for (int i = 1; i <= 3; i++) begin
            #1;
            chk($sformatf("to2_wait%0d_err", i), bus4.err_out, 0);
            tick();
        end
        bus4.mem_done = 1; bus4.mem_rdata = 16'h5A5A;
        #1;
        chk("to2_done_stall", bus4.stall_out, 0);
        chk("to2_done_rdata", bus4.read_data_out, 16'h5A5A);
        chk("to2_done_err", bus4.err_out, 0);
        tick(); idle4(); #1;
        chk("to2_state", st4, 0);
        chk("to2_err_after", bus4.err_out, 0);
        chk("to2_rdata_held", bus4.read_data_out, 16'h5A5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
Memory-stage controller that sits between the EX/MEM pipeline register and the MEM/WB pipeline register. It issues loads and stores to a multi-cycle, stallable data memory and holds the pipeline until the access completes. It delivers load data to MEM/WB and flags misaligned, conflicting or timed-out accesses as a sticky error.

Parameters:
TIMEOUT, 64, max cycles in REQ+WAIT before an access is declared failed (1..255)
CNT_W, 8, width of timeout counter; must hold TIMEOUT

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
valid_in  in  1  EX/MEM holds a valid instruction
mem_read_in  in  1  instruction is a load
mem_write_in  in  1  instruction is a store
addr_in  in  16  byte address from ALU result
wr_data_in  in  16  store data
mem_rd  out  1  read request to data memory
mem_wr  out  1  write request to data memory
mem_addr  out  16  address to data memory
mem_wdata  out  16  write data to data memory
mem_stall  in  1  memory busy; request not accepted this cycle
mem_done  in  1  access complete this cycle; mem_rdata valid for reads
mem_rdata  in  16  read data from memory
stall_out  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; drive MEM/WB en low
read_data_out  out  16  load data to MEM/WB read_data_in
err_out  out  1  sticky access error

Behaviour:
- States: IDLE, REQ (request held while memory busy), WAIT (accepted, awaiting done), ERR.
- op = valid_in & (mem_read_in | mem_write_in). bad = op & (addr_in[0] | (mem_read_in & mem_write_in)).
- IDLE:
  - op & ~bad: mem_rd/mem_wr follow mem_read_in/mem_write_in combinationally. mem_addr=addr_in, mem_wdata=wr_data_in. Latch addr, data, rd/wr into request registers.
  - Same-cycle transitions from IDLE:
    - mem_stall=1 -> REQ.
    - mem_stall=0 & mem_done=1 -> complete; stay IDLE.
    - mem_stall=0 & mem_done=0 -> WAIT.
  - bad -> ERR; no memory request is driven.
  - ~op -> stay IDLE; mem_rd=mem_wr=0.
- REQ: drive the latched request every cycle.
  - mem_stall=0 & mem_done -> IDLE.
  - mem_stall=0 & ~mem_done -> WAIT.
  - Otherwise stay in REQ.
- WAIT: mem_rd=mem_wr=0; mem_addr/mem_wdata hold the latched values. mem_done -> IDLE.
- ERR: absorbing until reset. err_out=1, stall_out=1, mem_rd=mem_wr=0.
- stall_out is combinational and equals 1 when any of these holds:
  - IDLE & op & ~(~mem_stall & mem_done), or IDLE & bad;
  - REQ or WAIT, and not (mem_done & ~mem_stall);
  - ERR.
  - It is 0 in the completion cycle, so MEM/WB captures the result on that edge.
- read_data_out: equals mem_rdata in a read completion cycle. Otherwise it equals the registered copy of the last completed read. Write completions leave it unchanged.
- Timeout counter:
  - Cleared in IDLE; increments each cycle spent in REQ or WAIT.
  - If it equals TIMEOUT with no completion that cycle, next state is ERR.
  - A completion on the same cycle the count is reached wins; no error.
- mem_done while ~op in IDLE is ignored (spurious) and does not update read_data_out.
- Environment rule: EX/MEM inputs are held stable while stall_out=1. The controller uses its latched copies in REQ/WAIT regardless.
- Reset (rst=0 at edge): state=IDLE, counter=0, held read data=0, err cleared.
  - While rst=0, all outputs are forced to 0.
  - A reset mid-access abandons the access; no completion is reported.

Test Plan:
- Single-cycle load: IDLE, valid, rd, addr=0x0010, mem_stall=0, mem_done=1, rdata=0xBEEF -> same cycle mem_rd=1, stall_out=0, read_data_out=0xBEEF; state stays IDLE.
- Busy then slow store: wr, addr=0x0100, data=0x1234; mem_stall=1 for 3 cycles, then 0; done 2 cycles later.
  - Required: mem_wr=1 for 4 cycles with addr/data held, stall_out=1 for 6 cycles, 0 on the done cycle; read_data_out unchanged.
- Misaligned load addr=0x0011 -> no mem_rd ever; stall_out=1 that cycle; err_out=1 from next cycle and holds until rst=0.
- Timeout with TIMEOUT=4: load accepted, mem_done never asserted -> ERR entered after 4 WAIT cycles, err_out=1. A variant with done on the 4th cycle shows no error.
- Reset mid-WAIT: rst=0 for one edge -> all outputs 0, state IDLE; a later done pulse with valid_in=0 leaves read_data_out=0.
- Back-to-back loads 0x0000, 0x0002 each completing in 2 cycles -> two stall windows of 1 cycle; read_data_out shows each rdata in its completion cycle.
